// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// forwarding select codes and the hard-wired zero register.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for one ALU source; the younger EX/MEM result
// wins over MEM/WB, and writes to the zero register are never forwarded.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] src_reg,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_write_reg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_write_reg,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && mem_write_reg != REG_ZERO && mem_write_reg == src_reg)
      sel = FWD_EXMEM;
    else if (wb_reg_write && wb_write_reg != REG_ZERO && wb_write_reg == src_reg)
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central hazard controller for the 5-stage MIPS core: freeze/flush/stall
// decisions, forwarding selects, multi-cycle memory sequencing and counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_jr,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_write_reg,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_write_reg,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_flush,
  output logic             ex_mem_enable,
  output logic             ex_mem_flush,
  output logic             mem_wb_enable,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout_err,
  output logic             hazard_state
);

  hz_state_t  state;
  logic [7:0] wait_cnt;
  logic       freeze;
  logic       load_use;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  forwarding_unit u_fwd_a (
    .src_reg       (ex_rs),
    .mem_reg_write (mem_reg_write),
    .mem_write_reg (mem_write_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .sel           (fwd_a_raw)
  );

  forwarding_unit u_fwd_b (
    .src_reg       (ex_rt),
    .mem_reg_write (mem_reg_write),
    .mem_write_reg (mem_write_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .sel           (fwd_b_raw)
  );

  // In MEM_WAIT the freeze holds until the memory answers; a forced release
  // still freezes its own cycle because the access never completed.
  assign freeze   = (state == MEM_WAIT) ? !mem_ready : (mem_access && !mem_ready);
  assign load_use = ex_mem_read && ex_rt != REG_ZERO &&
                    (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  assign hazard_state = state;

  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_enable = 1'b1;
    fwd_a_sel     = FWD_REG;
    fwd_b_sel     = FWD_REG;
    if (!reset) begin
      fwd_a_sel = fwd_a_raw;
      fwd_b_sel = fwd_b_raw;
      if (freeze) begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_enable = 1'b0;
      end else if (state == RUN) begin
        // Flushes outrank the load-use stall: the stalled instruction dies anyway.
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (ex_jr) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_jump) begin
          if_id_flush = 1'b1;
        end else if (load_use) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      wait_cnt        <= 8'd0;
      stall_cycles    <= '0;
      flush_events    <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_access && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
            mem_timeout_err <= 1'b1;
            state           <= RUN;
          end
        end
      endcase
      if (!pc_enable && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if ((if_id_flush || id_ex_flush || ex_mem_flush) && flush_events != '1)
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule
